// File: rtl/mem_initiator.sv
// mem_initiator: turns single core load/store requests into one-cycle
// strobes towards a 32-word synchronous RAM, handling acknowledge stalls,
// a stall timeout, misalignment errors and (optionally) sub-word accesses.
//
// Optional feature: define MEM_INITIATOR_SUBWORD_EN to enable byte/half
// accesses (lane-extended loads, read-modify-write stores). Without it
// every access is a word access and req_size/req_unsigned are ignored.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   req_read/req_write  core load/store request (taken only when idle)
//   req_addr            byte address (bits [6:2] select the RAM word)
//   req_wdata           store data
//   req_size            00 byte, 01 half, 10 word
//   req_unsigned        zero-extend sub-word loads
//   busy                transaction in flight
//   done, err           one-cycle completion pulse / error flag with done
//   rdata               load result, held until the next load completes
//   read_enable         RAM read strobe
//   write_enable        RAM write strobe
//   address_DM          RAM word address
//   data_in             RAM write data
//   data_out            RAM registered read data
//   pc_enable           RAM acknowledge, low = request taken this cycle
module mem_initiator #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        read_enable,
    output logic        write_enable,
    output logic [4:0]  address_DM,
    output logic [31:0] data_in,
    input  logic [31:0] data_out,
    input  logic        pc_enable
);

    localparam int unsigned WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        WR_WAIT,
        RESP
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [4:0]    r_word;
    logic [31:0]   r_rdata;
    logic [31:0]   r_data_in;
    logic          r_err;
    logic [WW-1:0] r_wait;

    logic          w_req;
    logic          w_misaligned;
    logic          w_rmw;
    logic          w_bad;
    logic          w_wait_last;
    logic [31:0]   w_load_val;
    logic          w_unused;

`ifdef MEM_INITIATOR_SUBWORD_EN
    logic [1:0]    r_lane;
    logic [1:0]    r_size;
    logic          r_unsigned;
    logic          r_is_store;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_merged;

    assign w_unused = &{1'b0, req_addr[31:7]};
`else
    assign w_unused = &{1'b0, req_addr[31:7], req_size, req_unsigned};
`endif

    assign w_req       = req_read | req_write;
    assign w_wait_last = (r_wait == WAIT_LAST);

    // Request classification, evaluated while IDLE.
    always_comb begin
        w_misaligned = |req_addr[1:0];
        w_rmw        = 1'b0;
`ifdef MEM_INITIATOR_SUBWORD_EN
        case (req_size)
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = req_addr[0];
            default: w_misaligned = |req_addr[1:0];
        endcase
        // Sub-word stores must fetch the word first to merge the lane.
        w_rmw = req_write & ~req_read & ~req_size[1];
`endif
        w_bad = (req_read & req_write) | w_misaligned;
    end

`ifdef MEM_INITIATOR_SUBWORD_EN
    // Lane extraction for loads and lane merge for read-modify-write.
    always_comb begin
        w_byte     = data_out[{r_lane, 3'b000} +: 8];
        w_half     = r_lane[1] ? data_out[31:16] : data_out[15:0];
        w_load_val = data_out;
        w_merged   = data_out;
        case (r_size)
            2'b00: begin
                w_load_val = {{24{~r_unsigned & w_byte[7]}}, w_byte};
                w_merged[{r_lane, 3'b000} +: 8] = r_data_in[7:0];
            end
            2'b01: begin
                w_load_val = {{16{~r_unsigned & w_half[15]}}, w_half};
                w_merged[{r_lane[1], 4'b0000} +: 16] = r_data_in[15:0];
            end
            default: begin
                w_load_val = data_out;
            end
        endcase
    end
`else
    assign w_load_val = data_out;
`endif

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (w_bad)
                        w_next = RESP;
                    else if (req_read | w_rmw)
                        w_next = RD_ISSUE;
                    else
                        w_next = WR_ISSUE;
                end
            end
            RD_ISSUE: begin
                if (!pc_enable)
                    w_next = RD_WAIT;
                else if (w_wait_last)
                    w_next = RESP;
            end
            RD_WAIT: begin
`ifdef MEM_INITIATOR_SUBWORD_EN
                w_next = r_is_store ? WR_ISSUE : RESP;
`else
                w_next = RESP;
`endif
            end
            WR_ISSUE: begin
                if (!pc_enable)
                    w_next = WR_WAIT;
                else if (w_wait_last)
                    w_next = RESP;
            end
            WR_WAIT: w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        busy         = (r_state != IDLE);
        done         = (r_state == RESP);
        err          = (r_state == RESP) & r_err;
        read_enable  = (r_state == RD_ISSUE);
        write_enable = (r_state == WR_ISSUE);
    end

    assign rdata      = r_rdata;
    assign address_DM = r_word;
    assign data_in    = r_data_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_word     <= '0;
            r_rdata    <= '0;
            r_data_in  <= '0;
            r_err      <= 1'b0;
            r_wait     <= '0;
`ifdef MEM_INITIATOR_SUBWORD_EN
            r_lane     <= '0;
            r_size     <= '0;
            r_unsigned <= 1'b0;
            r_is_store <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_word    <= req_addr[6:2];
                        r_data_in <= req_wdata;
                        r_err     <= w_bad;
                        r_wait    <= '0;
`ifdef MEM_INITIATOR_SUBWORD_EN
                        r_lane     <= req_addr[1:0];
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_is_store <= req_write;
`endif
                    end
                end
                RD_ISSUE, WR_ISSUE: begin
                    // Counter restarts on acknowledge so the write phase of
                    // a read-modify-write gets its own full timeout budget.
                    if (pc_enable) begin
                        r_wait <= r_wait + 1'b1;
                        if (w_wait_last)
                            r_err <= 1'b1;
                    end else begin
                        r_wait <= '0;
                    end
                end
                RD_WAIT: begin
`ifdef MEM_INITIATOR_SUBWORD_EN
                    if (r_is_store)
                        r_data_in <= w_merged;
                    else
                        r_rdata <= w_load_val;
`else
                    r_rdata <= w_load_val;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_initiator.md
MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: ISSUE-state cycles allowed without RAM acknowledge before abort.
REQ-002 SHALL have ports, one per line:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_read  in  1  core load request.
- req_write  in  1  core store request.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_size  in  2  00 byte, 01 half, 10 word.
- req_unsigned  in  1  zero-extend sub-word loads.
- busy  out  1  transaction in flight.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse, coincident with done.
- rdata  out  32  load result, valid while done=1.
- read_enable  out  1  RAM read strobe.
- write_enable  out  1  RAM write strobe.
- address_DM  out  5  RAM word address.
- data_in  out  32  RAM write data.
- data_out  in  32  RAM registered read data.
- pc_enable  in  1  RAM acknowledge; low = request taken this cycle.
REQ-003 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-004 SHALL implement FSM with states IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, RESP.
REQ-005 SHALL accept a request only in IDLE and register addr, wdata, size and unsigned; requests are ignored while busy=1.
REQ-006 SHALL drive busy=1 in every state except IDLE.
REQ-007 SHALL drive address_DM = registered addr[6:2]; upper address bits are ignored and wrap modulo 32 words.
REQ-008 SHALL assert read_enable only in RD_ISSUE and write_enable only in WR_ISSUE; both strobes SHALL be low in all other states.
REQ-009 SHALL leave an ISSUE state for the matching WAIT state on the cycle pc_enable=0, and stay in ISSUE while pc_enable=1.
REQ-010 SHALL abort after MAX_WAIT consecutive ISSUE cycles with pc_enable=1: go to RESP with err=1, with no further strobes.
REQ-011 SHALL deassert the strobe in the WAIT states and hold address_DM; WAIT lasts exactly one cycle; data_out is captured at the end of RD_WAIT.
REQ-012 Load path SHALL be IDLE->RD_ISSUE->RD_WAIT->RESP, so done is at T+3 after acceptance at T with immediate acknowledge.
REQ-013 Word-store path SHALL be IDLE->WR_ISSUE->WR_WAIT->RESP, so done is at T+3.
REQ-014 RESP SHALL last one cycle with done=1, then return to IDLE; rdata SHALL hold its value until the next load completes.
REQ-015 Requests with both req_read and req_write high, or misaligned requests, SHALL go IDLE->RESP with err=1 and no RAM access.
REQ-016 Misaligned SHALL mean word with addr[1:0]!=0, or half with addr[0]=1.

Reset
REQ-017 On rst=1 at a clock edge, the block SHALL enter IDLE and drive busy, done, err, read_enable and write_enable to 0, and rdata, address_DM and data_in to 0.
REQ-018 Reset mid-transaction SHALL abandon the transaction without a done pulse; a strobe SHALL NOT be asserted in the cycle after reset.

Configuration
REQ-019 With macro MEM_INITIATOR_SUBWORD_EN defined, the block SHALL support byte and half accesses:
- Loads: select the lane by addr[1:0] and extend it, zero-extend if req_unsigned=1, else sign-extend.
- Stores: read-modify-write via IDLE->RD_ISSUE->RD_WAIT->WR_ISSUE->WR_WAIT->RESP (done at T+5), merging req_wdata low bits into the addressed lane of the captured word.
REQ-020 Without MEM_INITIATOR_SUBWORD_EN, the block SHALL ignore req_size and req_unsigned, treat every access as a word access, and apply only the word misalignment rule.

Verification
REQ-021 Word load: req_read=1, addr=0x0C, RAM word 3=0xDEADBEEF, immediate ack -> read_enable high at T+1 only, done=1 and rdata=0xDEADBEEF at T+3.
REQ-022 Word store: req_write=1, addr=0x10, wdata=0x12345678 -> write_enable high one cycle, address_DM=4, data_in=0x12345678, done at T+3; a subsequent load returns 0x12345678.
REQ-023 Sub-word (macro on): RAM word 1=0xAABBCCDD; store byte 0x11 to addr 0x06 -> done at T+5, word 1=0xAA11CCDD; signed byte load addr 0x07 -> rdata=0xFFFFFFAA.
REQ-024 Error: word load at addr 0x02 -> no strobe, done=1 and err=1 at T+1; pc_enable held high for 15 cycles -> abort with err=1.
REQ-025 Reset in RD_WAIT -> next cycle busy=0, both strobes 0, no done; a new load completes normally.
